pulse_meter: RTL and testbench
==============================

PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 26, width of WIDTH/PERIOD counters in CLK cycles.
REQ-002 SHALL have parameter TMO_CYC, default 32000000, edge-free cycles before timeout (about 1 s at 32 MHz).
REQ-003 SHALL have parameter MIN_W, default 4, minimum accepted high time in cycles; used only under the configuration macro.
REQ-004 SHALL have port CLK  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port PULSE_IN  input  1  asynchronous pulse train under measurement (pulser/LED-style output).
REQ-007 SHALL have port WIDTH  output  CNT_W  measured high time, CLK cycles.
REQ-008 SHALL have port PERIOD  output  CNT_W  measured rise-to-rise time, CLK cycles.
REQ-009 SHALL have port VALID  output  1  result available.
REQ-010 SHALL have port ACK  input  1  consumer accepts result.
REQ-011 SHALL have port OVERFLOW  output  1  a counter saturated in the current result.
REQ-012 SHALL have port TMO  output  1  one-cycle pulse on timeout.
REQ-013 SHALL have port MISS  output  1  one-cycle pulse when a completed result is discarded.

Function
REQ-014 SHALL pass PULSE_IN through a 2-flop synchronizer plus an edge register, giving rise/fall strobes 3 CLK after the input edge.
REQ-015 SHALL implement states IDLE, HIGH, LOW; IDLE -> HIGH on rise, with width and period counters loaded to 1.
REQ-016 In HIGH, both counters SHALL increment each cycle; on fall the width count is latched and the state goes to LOW.
REQ-017 In LOW, the period counter SHALL increment; on rise a result completes and the state goes to HIGH with both counters reloaded to 1.
REQ-018 On completion, WIDTH/PERIOD/OVERFLOW SHALL update and VALID SHALL rise on the next CLK, i.e. 4 CLK after the input rise.
REQ-019 WIDTH, PERIOD and OVERFLOW SHALL stay stable while VALID=1; VALID SHALL clear on the cycle after ACK=1 is sampled.
REQ-020 If a result completes while VALID=1 and ACK=0, the new result SHALL be discarded and MISS SHALL pulse for 1 cycle.
REQ-021 If completion and ACK coincide, the new result SHALL be loaded, VALID SHALL stay 1, and no MISS SHALL occur.
REQ-022 Counters SHALL saturate at 2^CNT_W-1, never wrap, and set OVERFLOW in that result.
REQ-023 After TMO_CYC cycles without an edge in HIGH or LOW, the block SHALL go to IDLE, pulse TMO for 1 cycle and produce no result.
REQ-024 A held VALID SHALL be unaffected by a timeout.
REQ-025 ACK while VALID=0 SHALL be ignored.

Reset
REQ-026 RST=1 SHALL asynchronously clear synchronizer flops, counters, WIDTH, PERIOD, VALID, OVERFLOW, TMO and MISS to 0, and set state to IDLE.
REQ-027 Reset mid-measurement SHALL discard the partial result; the first result after release SHALL need two rises.

Configuration
REQ-028 With PULSE_METER_GLITCH_FILTER_EN defined, a high phase shorter than MIN_W cycles SHALL be ignored: no state change, and its cycles counted into the ongoing period (or ignored in IDLE).
REQ-029 Without PULSE_METER_GLITCH_FILTER_EN, every high phase of 1 cycle or more SHALL be measured, and MIN_W SHALL have no effect.

Structure
REQ-030 Package pulse_meter_pkg SHALL hold the state enum (IDLE, HIGH, LOW) and default CNT_W/TMO_CYC/MIN_W constants.
REQ-031 Synchronizer plus edge detect SHALL be sub-module pulse_edge_sync (ports CLK, RST, async in, rise, fall).

Verification
REQ-032 Pulses high 10, period 40 cycles -> WIDTH=10, PERIOD=40, VALID rises 4 CLK after the second input rise.
REQ-033 ACK held 0 across three periods -> first result held, MISS pulses twice; ACK=1 -> VALID=0 the next cycle.
REQ-034 TMO_CYC=100, input stuck high 150 cycles after a rise -> TMO pulses at the 100th edge-free cycle, state IDLE, VALID stays 0.
REQ-035 CNT_W=8, period 300 cycles -> PERIOD=255, OVERFLOW=1.
REQ-036 Filter macro on with MIN_W=4, 2-cycle glitch inside LOW -> no result and period unaffected; macro off -> WIDTH=2 reported.
REQ-037 RST pulse during HIGH -> all outputs 0 within the same cycle; the next VALID appears only after two further rises.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared types and default sizing for the pulse_meter block.
// Default counter width, timeout length, and minimum high time used by the glitch filter.
package pulse_meter_pkg;

    localparam int DEF_CNT_W   = 26;
    localparam int DEF_TMO_CYC = 32000000;
    localparam int DEF_MIN_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_edge_sync.sv
// Purpose: brings an asynchronous pulse input into CLK and emits single-cycle RISE/FALL strobes.
// Latency: a strobe is produced 3 CLK after the input edge (2 synchronizer flops, then a registered compare).
// Backpressure: none; this is a free-running detector.
module pulse_edge_sync (
    input  logic CLK,
    input  logic RST,
    input  logic ASYNC_IN,
    output logic RISE,
    output logic FALL
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            RISE   <= 1'b0;
            FALL   <= 1'b0;
        end else begin
            meta_q <= ASYNC_IN;
            sync_q <= meta_q;
            prev_q <= sync_q;
            RISE   <= sync_q & ~prev_q;
            FALL   <= ~sync_q & prev_q;
        end
    end

endmodule

// File: rtl/pulse_meter.sv
// Purpose: measures high time and rise-to-rise period of PULSE_IN; PULSE_METER_GLITCH_FILTER_EN drops short highs.
// Latency: a result is presented with VALID 4 CLK after the input rise that completes it.
// Backpressure: VALID is held until ACK; a result completing while held and unacknowledged is dropped with MISS.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TMO_CYC = DEF_TMO_CYC,
    parameter int MIN_W   = DEF_MIN_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PULSE_IN,
    output logic [CNT_W-1:0] WIDTH,
    output logic [CNT_W-1:0] PERIOD,
    output logic             VALID,
    input  logic             ACK,
    output logic             OVERFLOW,
    output logic             TMO,
    output logic             MISS
);

    localparam int TMO_W  = $clog2(TMO_CYC + 1);
    localparam int PEND_W = $clog2(MIN_W + 2);

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MIN   = CNT_W'(MIN_W);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_LAST = PEND_W'(MIN_W - 1);

`ifdef PULSE_METER_GLITCH_FILTER_EN
    localparam bit FILT = (MIN_W > 1);
`else
    localparam bit FILT = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic             rise;
    logic             fall;
    state_t           state;
    logic [CNT_W-1:0] wid_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] wid_lat;
    logic             wid_ovf;
    logic             per_ovf;
    logic             wid_ovf_lat;
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout;

    logic              pend;
    logic [PEND_W-1:0] pend_cnt;
    logic [CNT_W-1:0]  cand_p;
    logic              cand_ovf;

    logic             start;
    logic [CNT_W-1:0] start_cnt;
    logic             done;
    logic [CNT_W-1:0] done_p;
    logic             done_po;

    pulse_edge_sync u_edge_sync (
        .CLK      (CLK),
        .RST      (RST),
        .ASYNC_IN (PULSE_IN),
        .RISE     (rise),
        .FALL     (fall)
    );

    // With the filter, a high phase only starts once it has lasted MIN_W cycles;
    // the period snapshot is taken at the rise so the result is still rise-to-rise.
    assign start     = FILT ? (pend && !fall && (pend_cnt == PEND_LAST))
                            : (rise && (state != HIGH));
    assign start_cnt = FILT ? CNT_MIN : CNT_ONE;
    assign done_p    = FILT ? cand_p : per_cnt;
    assign done_po   = (FILT ? cand_ovf : per_ovf) | wid_ovf_lat;
    assign done      = start && (state == LOW);
    assign timeout   = (state != IDLE) && !rise && !fall && (tmo_cnt == TMO_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend     <= 1'b0;
            pend_cnt <= '0;
            cand_p   <= '0;
            cand_ovf <= 1'b0;
        end else if (pend) begin
            if (fall || start) begin
                pend <= 1'b0;
            end
            pend_cnt <= pend_cnt + PEND_ONE;
        end else if (rise && (state != HIGH)) begin
            pend     <= 1'b1;
            pend_cnt <= PEND_ONE;
            cand_p   <= per_cnt;
            cand_ovf <= per_ovf;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            wid_cnt     <= '0;
            per_cnt     <= '0;
            wid_lat     <= '0;
            wid_ovf     <= 1'b0;
            per_ovf     <= 1'b0;
            wid_ovf_lat <= 1'b0;
            tmo_cnt     <= '0;
            TMO         <= 1'b0;
        end else begin
            TMO <= timeout;
            if ((state == IDLE) || rise || fall) begin
                tmo_cnt <= '0;
            end else if (!timeout) begin
                tmo_cnt <= tmo_cnt + TMO_ONE;
            end

            if (timeout) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state   <= HIGH;
                            wid_cnt <= start_cnt;
                            per_cnt <= start_cnt;
                            wid_ovf <= 1'b0;
                            per_ovf <= 1'b0;
                        end
                    end
                    HIGH: begin
                        per_cnt <= sat_inc(per_cnt);
                        per_ovf <= per_ovf | (per_cnt == CNT_MAX);
                        if (fall) begin
                            wid_lat     <= wid_cnt;
                            wid_ovf_lat <= wid_ovf;
                            state       <= LOW;
                        end else begin
                            wid_cnt <= sat_inc(wid_cnt);
                            wid_ovf <= wid_ovf | (wid_cnt == CNT_MAX);
                        end
                    end
                    LOW: begin
                        if (start) begin
                            state   <= HIGH;
                            wid_cnt <= start_cnt;
                            per_cnt <= start_cnt;
                            wid_ovf <= 1'b0;
                            per_ovf <= 1'b0;
                        end else begin
                            per_cnt <= sat_inc(per_cnt);
                            per_ovf <= per_ovf | (per_cnt == CNT_MAX);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Result holding register: a fresh result may replace the held one only when it is being acknowledged.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WIDTH    <= '0;
            PERIOD   <= '0;
            OVERFLOW <= 1'b0;
            VALID    <= 1'b0;
            MISS     <= 1'b0;
        end else begin
            MISS <= 1'b0;
            if (done && (!VALID || ACK)) begin
                WIDTH    <= wid_lat;
                PERIOD   <= done_p;
                OVERFLOW <= done_po;
                VALID    <= 1'b1;
            end else if (done) begin
                MISS <= 1'b1;
            end else if (VALID && ACK) begin
                VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: latency, hold/ack/miss, timeout, saturation, glitch handling, reset.
module tb_pulse_meter;

    logic        clk;
    logic        rst;
    logic        pulse_in;
    logic        ack;

    logic [15:0] width;
    logic [15:0] period;
    logic        valid;
    logic        overflow;
    logic        tmo;
    logic        miss;

    logic [7:0]  w8_width;
    logic [7:0]  w8_period;
    logic        w8_valid;
    logic        w8_overflow;
    logic        w8_tmo;
    logic        w8_miss;

    int checks     = 0;
    int errors     = 0;
    int miss_seen  = 0;
    int tmo_seen   = 0;
    int m0;
    int t0;

    pulse_meter #(.CNT_W(16), .TMO_CYC(100), .MIN_W(4)) dut (
        .CLK      (clk),
        .RST      (rst),
        .PULSE_IN (pulse_in),
        .WIDTH    (width),
        .PERIOD   (period),
        .VALID    (valid),
        .ACK      (ack),
        .OVERFLOW (overflow),
        .TMO      (tmo),
        .MISS     (miss)
    );

    pulse_meter #(.CNT_W(8), .TMO_CYC(1000), .MIN_W(4)) u_w8 (
        .CLK      (clk),
        .RST      (rst),
        .PULSE_IN (pulse_in),
        .WIDTH    (w8_width),
        .PERIOD   (w8_period),
        .VALID    (w8_valid),
        .ACK      (ack),
        .OVERFLOW (w8_overflow),
        .TMO      (w8_tmo),
        .MISS     (w8_miss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (miss === 1'b1) miss_seen++;
        if (tmo === 1'b1) tmo_seen++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog sim_time_limit got=expired exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pulse_in = 1'b0;
        ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Called just after a rising clock edge; returns just after a rising edge.
    task automatic drive_pulse(input int hi, input int per);
        pulse_in = 1'b1;
        repeat (hi) @(posedge clk);
        #1 pulse_in = 1'b0;
        repeat (per - hi) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pulse_in = 1'b0;
        ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_width", width, 0);
        chk("rst_period", period, 0);
        chk("rst_valid", valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tmo", tmo, 0);
        chk("rst_miss", miss, 0);

        // Basic measurement and VALID latency
        do_reset();
        fork
            begin
                drive_pulse(10, 40);
                drive_pulse(10, 40);
            end
            begin
                repeat (43) @(posedge clk);
                @(negedge clk);
                chk("a_lat_early", valid, 0);
                @(negedge clk);
                chk("a_lat_valid", valid, 1);
            end
        join
        chk("a_width", width, 10);
        chk("a_period", period, 40);
        chk("a_overflow", overflow, 0);
        chk("a_w8_period", w8_period, 40);
        chk("a_w8_overflow", w8_overflow, 0);
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        @(negedge clk);
        chk("a_ack_clear", valid, 0);

        // Held result, misses, and completion coinciding with ACK
        do_reset();
        m0 = miss_seen;
        drive_pulse(6, 30);
        drive_pulse(9, 30);
        drive_pulse(12, 30);
        drive_pulse(3, 30);
        fork
            drive_pulse(4, 30);
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("b_hold_valid", valid, 1);
                chk("b_hold_width", width, 6);
                chk("b_hold_period", period, 30);
                chk("b_miss_count", miss_seen - m0, 2);
                ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
                @(negedge clk);
                chk("b_coin_valid", valid, 1);
                chk("b_coin_width", width, 3);
                chk("b_coin_period", period, 30);
                chk("b_coin_nomiss", miss_seen - m0, 2);
            end
        join
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        @(negedge clk);
        chk("b_ack_clear", valid, 0);
        ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 ack = 1'b0;
        chk("b_idle_ack", valid, 0);
        pulse_in = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("b_after_valid", valid, 1);
        chk("b_after_width", width, 4);
        chk("b_after_period", period, 34);

        // Timeout while stuck high, then recovery from IDLE
        do_reset();
        t0 = tmo_seen;
        pulse_in = 1'b1;
        repeat (103) @(posedge clk);
        @(negedge clk);
        chk("c_tmo_early", tmo, 0);
        @(negedge clk);
        chk("c_tmo_pulse", tmo, 1);
        @(negedge clk);
        chk("c_tmo_once", tmo, 0);
        chk("c_tmo_novalid", valid, 0);
        repeat (45) @(posedge clk);
        #1 pulse_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("c_tmo_count", tmo_seen - t0, 1);
        chk("c_fall_novalid", valid, 0);
        drive_pulse(5, 20);
        drive_pulse(5, 20);
        chk("c_idle_valid", valid, 1);
        chk("c_idle_width", width, 5);
        chk("c_idle_period", period, 20);
        t0 = tmo_seen;
        repeat (110) @(posedge clk);
        @(negedge clk);
        chk("c_hold_tmo", tmo_seen - t0, 1);
        chk("c_hold_valid", valid, 1);
        chk("c_hold_width", width, 5);

        // Period saturation on the 8-bit instance
        do_reset();
        drive_pulse(10, 300);
        pulse_in = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("d_valid", w8_valid, 1);
        chk("d_period", w8_period, 255);
        chk("d_overflow", w8_overflow, 1);
        chk("d_width", w8_width, 10);
        chk("d_notmo", w8_tmo, 0);
        chk("d_nomiss", w8_miss, 0);

        // Two-cycle glitch inside the low phase
        do_reset();
        drive_pulse(10, 20);
        fork
            drive_pulse(2, 20);
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
`ifdef PULSE_METER_GLITCH_FILTER_EN
                chk("e_glitch_none", valid, 0);
`else
                chk("e_first_valid", valid, 1);
                chk("e_first_width", width, 10);
                chk("e_first_period", period, 20);
                ack = 1'b1;
                @(posedge clk);
                #1 ack = 1'b0;
`endif
            end
        join
        pulse_in = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
`ifdef PULSE_METER_GLITCH_FILTER_EN
        chk("e_valid", valid, 1);
        chk("e_width", width, 10);
        chk("e_period", period, 40);
`else
        chk("e_valid", valid, 1);
        chk("e_width", width, 2);
        chk("e_period", period, 20);
`endif

        // Reset during a high phase
        do_reset();
        drive_pulse(10, 40);
        pulse_in = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("f_pre_valid", valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("f_rst_valid", valid, 0);
        chk("f_rst_width", width, 0);
        chk("f_rst_period", period, 0);
        chk("f_rst_overflow", overflow, 0);
        pulse_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        drive_pulse(10, 40);
        chk("f_one_rise", valid, 0);
        fork
            drive_pulse(10, 40);
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("f_two_early", valid, 0);
                @(negedge clk);
                chk("f_two_valid", valid, 1);
                chk("f_two_width", width, 10);
                chk("f_two_period", period, 40);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
